id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage that sits directly upstream of the ALU. It captures an RV32I instruction with its register-file read data, then generates the immediate and resolves operand forwarding from the two downstream stages. It registers operand A, operand B and the 4-bit ALU control code into a single-entry valid/ready pipeline slot. Holding, stalling and flushing this slot are handled here; the ALU itself stays purely combinational.

---
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline slot: decodes an RV32I word, forwards operands from EX/MEM and MEM/WB,
// and registers ALU operands plus control into a single valid/ready entry.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            exm_valid,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      alu_ctrl,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] store_data
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_NONE = 4'b0000;

    logic [4:0]      rs1_f, rs2_f;
    logic [2:0]      funct3;
    logic [6:0]      opcode;
    logic [XLEN-1:0] fwd1, fwd2, imm_i, imm_s;
    logic [XLEN-1:0] a_d, b_d, sd_d;
    logic [3:0]      ctrl_d;
    logic            rw_d, mr_d, mw_d;
    logic            capture;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

    // x0 never forwards; EX/MEM is the younger result so it wins over MEM/WB.
    assign fwd1 = (rs1_f == 5'd0)                  ? rs1_data   :
                  (exm_valid && exm_rd == rs1_f)   ? exm_result :
                  (wb_valid  && wb_rd  == rs1_f)   ? wb_result  : rs1_data;
    assign fwd2 = (rs2_f == 5'd0)                  ? rs2_data   :
                  (exm_valid && exm_rd == rs2_f)   ? exm_result :
                  (wb_valid  && wb_rd  == rs2_f)   ? wb_result  : rs2_data;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        a_d    = '0;
        b_d    = '0;
        sd_d   = '0;
        ctrl_d = CTRL_NONE;
        rw_d   = 1'b0;
        mr_d   = 1'b0;
        mw_d   = 1'b0;
        case (opcode)
            OP_R: begin
                a_d  = fwd1;
                b_d  = fwd2;
                rw_d = 1'b1;
                if (funct3 == 3'b000) ctrl_d = instr[30] ? CTRL_SUB : CTRL_ADD;
            end
            OP_I: begin
                a_d  = fwd1;
                b_d  = imm_i;
                rw_d = 1'b1;
                if (funct3 == 3'b000) ctrl_d = CTRL_ADD;
            end
            OP_LOAD: begin
                a_d    = fwd1;
                b_d    = imm_i;
                ctrl_d = CTRL_ADD;
                rw_d   = 1'b1;
                mr_d   = 1'b1;
            end
            OP_STORE: begin
                a_d    = fwd1;
                b_d    = imm_s;
                sd_d   = fwd2;
                ctrl_d = CTRL_ADD;
                mw_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            a          <= '0;
            b          <= '0;
            store_data <= '0;
            alu_ctrl   <= CTRL_NONE;
            rd         <= '0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            alu_ctrl  <= CTRL_NONE;
            rd        <= '0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            a          <= a_d;
            b          <= b_d;
            store_data <= sd_d;
            alu_ctrl   <= ctrl_d;
            rd         <= rw_d ? instr[11:7] : 5'd0;
            reg_write  <= rw_d;
            mem_read   <= mr_d;
            mem_write  <= mw_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by randomized traffic,
// each cycle compared against a transaction-level model of the slot.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0;
    logic        exm_valid = 1'b0, wb_valid = 1'b0;
    logic [4:0]  exm_rd = '0, wb_rd = '0;
    logic [31:0] exm_result = '0, wb_result = '0;
    logic        flush = 1'b0, out_valid, out_ready = 1'b1;
    logic [31:0] a, b, store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write;

    int compared = 0;
    int mismatched = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .exm_valid(exm_valid), .exm_rd(exm_rd),
        .exm_result(exm_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
        .alu_ctrl(alu_ctrl), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .store_data(store_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a, b, sd;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } op_t;

    // model state: what the slot should hold
    op_t m;
    logic m_valid;
    logic m_cleared;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] src_val(input logic [4:0] field, input logic [31:0] rf);
        if (field == 0) return rf;
        if (exm_valid && exm_rd == field) return exm_result;
        if (wb_valid && wb_rd == field) return wb_result;
        return rf;
    endfunction

    function automatic op_t decode();
        op_t e;
        logic [31:0] v1, v2;
        logic [11:0] imm_s;
        v1 = src_val(instr[19:15], rs1_data);
        v2 = src_val(instr[24:20], rs2_data);
        imm_s = {instr[31:25], instr[11:7]};
        e = '{a: 0, b: 0, sd: 0, ctrl: 0, rd: 0, rw: 0, mr: 0, mw: 0};
        case (instr[6:0])
            7'h33: begin
                e.a = v1; e.b = v2; e.rw = 1;
                e.ctrl = (instr[14:12] != 0) ? 4'd0 : (instr[30] ? 4'd6 : 4'd2);
            end
            7'h13: begin
                e.a = v1; e.b = 32'($signed(instr[31:20])); e.rw = 1;
                e.ctrl = (instr[14:12] == 0) ? 4'd2 : 4'd0;
            end
            7'h03: begin
                e.a = v1; e.b = 32'($signed(instr[31:20])); e.ctrl = 2; e.rw = 1; e.mr = 1;
            end
            7'h23: begin
                e.a = v1; e.b = 32'($signed(imm_s)); e.ctrl = 2; e.mw = 1; e.sd = v2;
            end
            default: ;
        endcase
        e.rd = e.rw ? instr[11:7] : 5'd0;
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_cleared = 1;
        m = '{a: 0, b: 0, sd: 0, ctrl: 0, rd: 0, rw: 0, mr: 0, mw: 0};
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        if (m_valid || m_cleared) begin
            chk({tag, ".reg_write"}, 32'(reg_write), 32'(m.rw));
            chk({tag, ".mem_read"}, 32'(mem_read), 32'(m.mr));
            chk({tag, ".mem_write"}, 32'(mem_write), 32'(m.mw));
        end
        if (m_valid) begin
            chk({tag, ".a"}, a, m.a);
            chk({tag, ".b"}, b, m.b);
            chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(m.ctrl));
            chk({tag, ".rd"}, 32'(rd), 32'(m.rd));
            if (m.mw) chk({tag, ".store_data"}, store_data, m.sd);
        end
    endtask

    // Inputs are already driven; advance one clock edge and compare.
    task automatic step(input string tag);
        logic cap;
        op_t nxt;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
        cap = in_valid && (!m_valid || out_ready) && !flush;
        nxt = decode();
        @(posedge clk);
        if (flush) begin
            m_valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m_cleared = 1;
        end else if (cap) begin
            m = nxt; m_valid = 1; m_cleared = 0;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input logic iv, input logic ordy, input logic fl);
        instr = ins; rs1_data = r1; rs2_data = r2;
        in_valid = iv; out_ready = ordy; flush = fl;
    endtask

    task automatic fwd_set(input logic ev, input logic [4:0] er, input logic [31:0] ex,
                           input logic wv, input logic [4:0] wr, input logic [31:0] wx);
        exm_valid = ev; exm_rd = er; exm_result = ex;
        wb_valid = wv; wb_rd = wr; wb_result = wx;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        case ($urandom_range(0, 5))
            0, 5: op = 7'h33;
            1: op = 7'h13;
            2: op = 7'h03;
            3: op = 7'h23;
            default: op = ($urandom_range(0, 1) != 0) ? 7'h63 : 7'h37;
        endcase
        f7 = 7'($urandom);
        f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
                5'($urandom), op};
    endfunction

    initial begin
        model_reset();
        fwd_set(0, 0, 0, 0, 0, 0);
        #12;
        check_outputs("reset_low");
        chk("reset_low.alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("reset_low.a", a, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check_outputs("idle");
        chk("idle.in_ready", 32'(in_ready), 32'd1);
        chk("idle.alu_ctrl", 32'(alu_ctrl), 32'd0);

        drive(32'h002081B3, 5, 7, 1, 1, 0);
        step("add");
        chk("add.a_const", a, 5); chk("add.b_const", b, 7);
        chk("add.ctrl_const", 32'(alu_ctrl), 32'b0010);
        chk("add.rd_const", 32'(rd), 3); chk("add.rw_const", 32'(reg_write), 1);

        drive(32'h402081B3, 5, 7, 1, 1, 0);
        step("sub");
        chk("sub.ctrl_const", 32'(alu_ctrl), 32'b0110);

        drive(32'hFFF08213, 10, 0, 1, 1, 0);
        step("addi");
        chk("addi.a_const", a, 10); chk("addi.b_const", b, 32'hFFFFFFFF);
        chk("addi.ctrl_const", 32'(alu_ctrl), 32'b0010);

        drive(32'h0020A423, 1, 32'h55, 1, 1, 0);
        step("sw");
        chk("sw.b_const", b, 8); chk("sw.mw_const", 32'(mem_write), 1);
        chk("sw.rw_const", 32'(reg_write), 0); chk("sw.rd_const", 32'(rd), 0);
        chk("sw.sd_const", store_data, 32'h55);

        fwd_set(1, 1, 32'h11, 1, 1, 32'h22);
        drive(32'h002081B3, 5, 7, 1, 1, 0);
        step("fwd_exm_prio");
        chk("fwd_exm_prio.a_const", a, 32'h11); chk("fwd_exm_prio.b_const", b, 7);

        fwd_set(1, 2, 32'h11, 1, 1, 32'h22);
        step("fwd_split");
        chk("fwd_split.a_const", a, 32'h22); chk("fwd_split.b_const", b, 32'h11);

        fwd_set(1, 0, 32'h11, 1, 0, 32'h22);
        drive(32'h000001B3, 0, 0, 1, 1, 0);
        step("fwd_x0");
        chk("fwd_x0.a_const", a, 0); chk("fwd_x0.b_const", b, 0);
        fwd_set(0, 0, 0, 0, 0, 0);

        drive(32'h002081B3, 5, 7, 1, 1, 0);
        step("hold_fill");
        fwd_set(1, 1, 32'h99, 0, 0, 0);
        drive(32'hFFF08213, 10, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("hold");
            chk("hold.in_ready_const", 32'(in_ready), 0);
            chk("hold.a_frozen", a, 5);
        end
        fwd_set(0, 0, 0, 0, 0, 0);
        out_ready = 1;
        step("hold_release");
        chk("hold_release.a_const", a, 10);
        chk("hold_release.valid_const", 32'(out_valid), 1);

        drive(32'h002081B3, 5, 7, 0, 1, 0);
        step("drain");
        chk("drain.a_kept", a, 10);

        drive(32'h002081B3, 5, 7, 1, 1, 0);
        step("flush_fill");
        drive(32'h00A00093, 3, 3, 1, 0, 0);
        step("flush_hold");
        flush = 1;
        step("flush");
        chk("flush.rw_const", 32'(reg_write), 0);
        flush = 0; in_valid = 0;
        step("flush_after");

        drive(32'h002081B3, 5, 7, 1, 1, 0);
        step("rst_fill");
        out_ready = 0;
        step("rst_hold");
        rst_n = 0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(negedge clk);
        rst_n = 1;
        drive(32'h402081B3, 9, 4, 1, 1, 0);
        step("rst_first_cap");
        chk("rst_first_cap.valid_const", 32'(out_valid), 1);

        for (int i = 0; i < 600; i++) begin
            fwd_set(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            drive(rand_instr(), $urandom, $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
